// File: rtl/axi4_slave_pkg.sv
// axi4_slave_pkg: shared burst/response/state types and beat stepping for axi4_slave_ram.
package axi4_slave_pkg;
   typedef enum logic [1:0] {FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10} burst_t;
   typedef enum logic [1:0] {OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11} resp_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
   typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rd_state_t;
   function automatic logic [7:0] beat_step(input logic [2:0] size);
      return 8'd1 << size;
   endfunction
endpackage

// File: rtl/axi4_slave_ram_rd_ctrl.sv
// axi4_slave_ram_rd_ctrl: AR/R channel FSM, beat address generator and registered rdata.
// With AXI4_SLAVE_RAM_ERR_EN, beats addressing above the RAM range return zero data and SLVERR.
module axi4_slave_ram_rd_ctrl
   import axi4_slave_pkg::*;
#(
   parameter int DEPTH_W = 8,
   parameter int IDSIZE  = 4,
   parameter int ASIZE   = 32,
   parameter int LSIZE   = 8,
   parameter int DSIZE   = 32,
   parameter bit RD_EN   = 1'b1
) (
   input  logic               axi_aclk,
   input  logic               axi_aresetn,
   input  logic [IDSIZE-1:0]  axi_arid,
   input  logic [ASIZE-1:0]   axi_araddr,
   input  logic [LSIZE-1:0]   axi_arlen,
   input  logic [2:0]         axi_arsize,
   input  logic [1:0]         axi_arburst,
   input  logic               axi_arvalid,
   output logic               axi_arready,
   output logic [IDSIZE-1:0]  axi_rid,
   output logic [DSIZE-1:0]   axi_rdata,
   output logic [1:0]         axi_rresp,
   output logic               axi_rlast,
   output logic               axi_rvalid,
   input  logic               axi_rready,
   output logic [DEPTH_W-1:0] ridx,
   input  logic [DSIZE-1:0]   rword
);
   localparam int LB = $clog2(DSIZE/8);
   rd_state_t rs_q, rs_d;
   burst_t burst_q, burst_d;
   logic [IDSIZE-1:0] rid_q, rid_d;
   logic [ASIZE-1:0] addr_q, addr_d, nxt;
   logic [LSIZE-1:0] len_q, len_d, cnt_q, cnt_d;
   logic [2:0] size_q, size_d;
   logic [DSIZE-1:0] rdata_q, rdata_d;
   logic [1:0] rresp_q, rresp_d;
   logic arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d, rerr;
   assign nxt = burst_q == FIXED ? addr_q : addr_q + ASIZE'(beat_step(size_q));
   // During R_DATA the next beat's word is looked up ahead so an accepted beat is replaced next cycle.
   assign ridx = rs_q == R_DATA ? nxt[DEPTH_W+LB-1:LB] : addr_q[DEPTH_W+LB-1:LB];
`ifdef AXI4_SLAVE_RAM_ERR_EN
   assign rerr = rs_q == R_DATA ? |nxt[ASIZE-1:DEPTH_W+LB] : |addr_q[ASIZE-1:DEPTH_W+LB];
`else
   assign rerr = 1'b0;
`endif
   always_comb begin
      rs_d = rs_q;
      rid_d = rid_q;
      addr_d = addr_q;
      len_d = len_q;
      cnt_d = cnt_q;
      size_d = size_q;
      burst_d = burst_q;
      rdata_d = rdata_q;
      rresp_d = rresp_q;
      rlast_d = rlast_q;
      case (rs_q)
         R_IDLE: if (axi_arvalid && arready_q) begin
            rs_d = R_FETCH;
            rid_d = axi_arid;
            addr_d = axi_araddr;
            len_d = axi_arlen;
            size_d = axi_arsize;
            burst_d = burst_t'(axi_arburst);
            cnt_d = '0;
         end
         R_FETCH: begin
            rs_d = R_DATA;
            rdata_d = rerr ? '0 : rword;
            rresp_d = rerr ? SLVERR : OKAY;
            rlast_d = len_q == '0;
         end
         R_DATA: if (axi_rready) begin
            if (rlast_q) rs_d = R_IDLE;
            else begin
               addr_d = nxt;
               cnt_d = cnt_q + 1'b1;
               rdata_d = rerr ? '0 : rword;
               rresp_d = rerr ? SLVERR : OKAY;
               rlast_d = cnt_q + 1'b1 == len_q;
            end
         end
         default: rs_d = R_IDLE;
      endcase
      arready_d = RD_EN && rs_d == R_IDLE;
      rvalid_d = rs_d == R_DATA;
   end
   always_ff @(posedge axi_aclk or negedge axi_aresetn)
      if (!axi_aresetn) begin
         rs_q <= R_IDLE;
         rid_q <= '0;
         addr_q <= '0;
         len_q <= '0;
         cnt_q <= '0;
         size_q <= '0;
         burst_q <= FIXED;
         rdata_q <= '0;
         rresp_q <= OKAY;
         rlast_q <= 1'b0;
         arready_q <= 1'b0;
         rvalid_q <= 1'b0;
      end else begin
         rs_q <= rs_d;
         rid_q <= rid_d;
         addr_q <= addr_d;
         len_q <= len_d;
         cnt_q <= cnt_d;
         size_q <= size_d;
         burst_q <= burst_d;
         rdata_q <= rdata_d;
         rresp_q <= rresp_d;
         rlast_q <= rlast_d;
         arready_q <= arready_d;
         rvalid_q <= rvalid_d;
      end
   assign axi_arready = arready_q;
   assign axi_rvalid = rvalid_q;
   assign axi_rid = rid_q;
   assign axi_rdata = rdata_q;
   assign axi_rresp = rresp_q;
   assign axi_rlast = rlast_q;
endmodule

// File: rtl/axi4_slave_ram.sv
// axi4_slave_ram: AXI4 slave terminating AW/W/B and AR/R bursts into a word RAM.
// Define AXI4_SLAVE_RAM_ERR_EN to flag out-of-range addresses and wlast mismatches with SLVERR.
module axi4_slave_ram
   import axi4_slave_pkg::*;
#(
   parameter int    DEPTH_W = 8,
   parameter int    IDSIZE  = 4,
   parameter int    ASIZE   = 32,
   parameter int    LSIZE   = 8,
   parameter int    DSIZE   = 32,
   parameter string MODE    = "BOTH"
) (
   input  logic               axi_aclk,
   input  logic               axi_aresetn,
   input  logic [IDSIZE-1:0]  axi_awid,
   input  logic [ASIZE-1:0]   axi_awaddr,
   input  logic [LSIZE-1:0]   axi_awlen,
   input  logic [2:0]         axi_awsize,
   input  logic [1:0]         axi_awburst,
   input  logic               axi_awvalid,
   output logic               axi_awready,
   input  logic [DSIZE-1:0]   axi_wdata,
   input  logic [DSIZE/8-1:0] axi_wstrb,
   input  logic               axi_wlast,
   input  logic               axi_wvalid,
   output logic               axi_wready,
   output logic [IDSIZE-1:0]  axi_bid,
   output logic [1:0]         axi_bresp,
   output logic               axi_bvalid,
   input  logic               axi_bready,
   input  logic [IDSIZE-1:0]  axi_arid,
   input  logic [ASIZE-1:0]   axi_araddr,
   input  logic [LSIZE-1:0]   axi_arlen,
   input  logic [2:0]         axi_arsize,
   input  logic [1:0]         axi_arburst,
   input  logic               axi_arvalid,
   output logic               axi_arready,
   output logic [IDSIZE-1:0]  axi_rid,
   output logic [DSIZE-1:0]   axi_rdata,
   output logic [1:0]         axi_rresp,
   output logic               axi_rlast,
   output logic               axi_rvalid,
   input  logic               axi_rready
);
   localparam int LB = $clog2(DSIZE/8);
   localparam bit WR_EN = MODE != "ONLY_READ";
   localparam bit RD_EN = MODE != "ONLY_WRITE";
   logic [DSIZE-1:0] mem [2**DEPTH_W];
   wr_state_t ws_q, ws_d;
   burst_t wburst_q, wburst_d;
   logic [IDSIZE-1:0] bid_q, bid_d;
   logic [ASIZE-1:0] waddr_q, waddr_d;
   logic [LSIZE-1:0] wlen_q, wlen_d, wcnt_q, wcnt_d;
   logic [2:0] wsize_q, wsize_d;
   logic awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
   logic wbeat, wen;
   logic [DEPTH_W-1:0] ridx;
   assign wbeat = wready_q && axi_wvalid;
`ifdef AXI4_SLAVE_RAM_ERR_EN
   logic werr_q, werr_d, oob;
   assign oob = |waddr_q[ASIZE-1:DEPTH_W+LB];
   assign wen = wbeat && !oob;
   assign axi_bresp = werr_q ? SLVERR : OKAY;
`else
   logic unused_wlast;
   assign unused_wlast = axi_wlast;
   assign wen = wbeat;
   assign axi_bresp = OKAY;
`endif
   always_comb begin
      ws_d = ws_q;
      bid_d = bid_q;
      waddr_d = waddr_q;
      wlen_d = wlen_q;
      wcnt_d = wcnt_q;
      wsize_d = wsize_q;
      wburst_d = wburst_q;
`ifdef AXI4_SLAVE_RAM_ERR_EN
      werr_d = werr_q;
`endif
      case (ws_q)
         W_IDLE: if (axi_awvalid && awready_q) begin
            ws_d = W_DATA;
            bid_d = axi_awid;
            waddr_d = axi_awaddr;
            wlen_d = axi_awlen;
            wsize_d = axi_awsize;
            wburst_d = burst_t'(axi_awburst);
            wcnt_d = '0;
`ifdef AXI4_SLAVE_RAM_ERR_EN
            werr_d = 1'b0;
`endif
         end
         W_DATA: if (wbeat) begin
            waddr_d = wburst_q == FIXED ? waddr_q : waddr_q + ASIZE'(beat_step(wsize_q));
            wcnt_d = wcnt_q + 1'b1;
`ifdef AXI4_SLAVE_RAM_ERR_EN
            werr_d = werr_q || oob || (axi_wlast != (wcnt_q == wlen_q));
`endif
            if (wcnt_q == wlen_q) ws_d = W_RESP;
         end
         W_RESP: if (axi_bready) ws_d = W_IDLE;
         default: ws_d = W_IDLE;
      endcase
      awready_d = WR_EN && ws_d == W_IDLE;
      wready_d = ws_d == W_DATA;
      bvalid_d = ws_d == W_RESP;
   end
   always_ff @(posedge axi_aclk or negedge axi_aresetn)
      if (!axi_aresetn) begin
         ws_q <= W_IDLE;
         bid_q <= '0;
         waddr_q <= '0;
         wlen_q <= '0;
         wcnt_q <= '0;
         wsize_q <= '0;
         wburst_q <= FIXED;
         awready_q <= 1'b0;
         wready_q <= 1'b0;
         bvalid_q <= 1'b0;
`ifdef AXI4_SLAVE_RAM_ERR_EN
         werr_q <= 1'b0;
`endif
      end else begin
         ws_q <= ws_d;
         bid_q <= bid_d;
         waddr_q <= waddr_d;
         wlen_q <= wlen_d;
         wcnt_q <= wcnt_d;
         wsize_q <= wsize_d;
         wburst_q <= wburst_d;
         awready_q <= awready_d;
         wready_q <= wready_d;
         bvalid_q <= bvalid_d;
`ifdef AXI4_SLAVE_RAM_ERR_EN
         werr_q <= werr_d;
`endif
      end
   always_ff @(posedge axi_aclk)
      if (wen)
         for (int i = 0; i < DSIZE/8; i++)
            if (axi_wstrb[i]) mem[waddr_q[DEPTH_W+LB-1:LB]][8*i +: 8] <= axi_wdata[8*i +: 8];
   assign axi_awready = awready_q;
   assign axi_wready = wready_q;
   assign axi_bvalid = bvalid_q;
   assign axi_bid = bid_q;
   axi4_slave_ram_rd_ctrl #(
      .DEPTH_W(DEPTH_W), .IDSIZE(IDSIZE), .ASIZE(ASIZE), .LSIZE(LSIZE), .DSIZE(DSIZE), .RD_EN(RD_EN)
   ) u_rd (
      .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
      .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
      .axi_arburst(axi_arburst), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
      .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
      .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
      .ridx(ridx), .rword(mem[ridx])
   );
endmodule

// File: tb/tb_axi4_slave_ram.sv
// tb_axi4_slave_ram: directed bursts against axi4_slave_ram in its default (no error checking) build.
module tb_axi4_slave_ram;
   logic clk = 1'b0, rst_n = 1'b0;
   logic [3:0] awid = '0, arid = '0, bid, rid;
   logic [31:0] awaddr = '0, araddr = '0, wdata = '0, rdata;
   logic [7:0] awlen = '0, arlen = '0;
   logic [2:0] awsize = 3'd2, arsize = 3'd2;
   logic [1:0] awburst = 2'b01, arburst = 2'b01, bresp, rresp;
   logic [3:0] wstrb = '0;
   logic awvalid = 1'b0, awready, wlast = 1'b0, wvalid = 1'b0, wready, bvalid, bready = 1'b0;
   logic arvalid = 1'b0, arready, rlast, rvalid, rready = 1'b0;
   int n_chk = 0, n_err = 0;
   logic [31:0] wd [4];
   logic [31:0] rx [4];
   int stall [4];
   always #5 clk = ~clk;
   axi4_slave_ram dut (
      .axi_aclk(clk), .axi_aresetn(rst_n),
      .axi_awid(awid), .axi_awaddr(awaddr), .axi_awlen(awlen), .axi_awsize(awsize), .axi_awburst(awburst),
      .axi_awvalid(awvalid), .axi_awready(awready),
      .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wlast(wlast), .axi_wvalid(wvalid), .axi_wready(wready),
      .axi_bid(bid), .axi_bresp(bresp), .axi_bvalid(bvalid), .axi_bready(bready),
      .axi_arid(arid), .axi_araddr(araddr), .axi_arlen(arlen), .axi_arsize(arsize), .axi_arburst(arburst),
      .axi_arvalid(arvalid), .axi_arready(arready),
      .axi_rid(rid), .axi_rdata(rdata), .axi_rresp(rresp), .axi_rlast(rlast), .axi_rvalid(rvalid),
      .axi_rready(rready)
   );
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic wr(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len, input logic [1:0] bu,
                     input logic [3:0] st, input int last_at, input int bwait);
      int t;
      awid = id; awaddr = a; awlen = len; awburst = bu; awvalid = 1'b1;
      t = 0;
      while (!awready && t < 20) begin tick(); t++; end
      chk("aw_ready", 32'(awready), 32'd1);
      tick();
      awvalid = 1'b0;
      for (int i = 0; i <= int'(len); i++) begin
         wdata = wd[i]; wstrb = st; wlast = (i == last_at); wvalid = 1'b1;
         t = 0;
         while (!wready && t < 20) begin tick(); t++; end
         chk("w_ready", 32'(wready), 32'd1);
         tick();
      end
      wvalid = 1'b0; wlast = 1'b0;
      t = 0;
      while (!bvalid && t < 20) begin tick(); t++; end
      chk("b_valid", 32'(bvalid), 32'd1);
      chk("b_id", 32'(bid), 32'(id));
      chk("b_resp", 32'(bresp), 32'd0);
      repeat (bwait) begin
         tick();
         chk("b_hold_valid", 32'(bvalid), 32'd1);
         chk("b_hold_id", 32'(bid), 32'(id));
      end
      bready = 1'b1;
      tick();
      bready = 1'b0;
      chk("b_done", 32'(bvalid), 32'd0);
   endtask
   task automatic rd(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len, input logic [1:0] bu);
      int t;
      arid = id; araddr = a; arlen = len; arburst = bu; arvalid = 1'b1;
      t = 0;
      while (!arready && t < 20) begin tick(); t++; end
      chk("ar_ready", 32'(arready), 32'd1);
      tick();
      arvalid = 1'b0;
      for (int i = 0; i <= int'(len); i++) begin
         t = 0;
         while (!rvalid && t < 20) begin tick(); t++; end
         chk("r_valid", 32'(rvalid), 32'd1);
         chk("r_data", rdata, rx[i]);
         chk("r_id", 32'(rid), 32'(id));
         chk("r_last", 32'(rlast), 32'(i == int'(len)));
         chk("r_resp", 32'(rresp), 32'd0);
         repeat (stall[i]) begin
            rready = 1'b0;
            tick();
            chk("r_hold_data", rdata, rx[i]);
            chk("r_hold_last", 32'(rlast), 32'(i == int'(len)));
         end
         rready = 1'b1;
         tick();
      end
      rready = 1'b0;
      chk("r_done", 32'(rvalid), 32'd0);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
      $fatal(1);
   end
   initial begin
      stall = '{0, 0, 0, 0};
      repeat (3) tick();
      chk("rst_awready", 32'(awready), 32'd0);
      chk("rst_arready", 32'(arready), 32'd0);
      chk("rst_bvalid", 32'(bvalid), 32'd0);
      chk("rst_rvalid", 32'(rvalid), 32'd0);
      chk("rst_wready", 32'(wready), 32'd0);
      rst_n = 1'b1;
      tick();
      chk("rel_awready", 32'(awready), 32'd1);
      chk("rel_arready", 32'(arready), 32'd1);
      wd = '{32'd1, 32'd2, 32'd3, 32'd4};
      wr(4'h5, 32'h40, 8'd3, 2'b01, 4'hF, 3, 5);
      rx = '{32'd1, 32'd2, 32'd3, 32'd4};
      stall = '{0, 2, 0, 0};
      rd(4'h3, 32'h40, 8'd3, 2'b01);
      stall = '{0, 0, 0, 0};
      wd[0] = 32'hFFFF_FFFF;
      wr(4'h1, 32'h80, 8'd0, 2'b01, 4'hF, 0, 0);
      wd[0] = 32'h0000_0000;
      wr(4'h2, 32'h80, 8'd0, 2'b01, 4'b0101, 0, 0);
      rx[0] = 32'hFF00_FF00;
      rd(4'h6, 32'h80, 8'd0, 2'b01);
      wd = '{32'hA, 32'hB, 32'hC, 32'h0};
      wr(4'h7, 32'h10, 8'd2, 2'b00, 4'hF, 2, 0);
      rx[0] = 32'hC;
      rd(4'h8, 32'h10, 8'd0, 2'b01);
      rx = '{32'hC, 32'hC, 32'h0, 32'h0};
      rd(4'h9, 32'h10, 8'd1, 2'b00);
      wd[0] = 32'h55;
      wr(4'hA, 32'h440, 8'd0, 2'b01, 4'hF, 0, 0);
      rx = '{32'h55, 32'd2, 32'd3, 32'd4};
      rd(4'hB, 32'h40, 8'd3, 2'b01);
      wd = '{32'h11, 32'h22, 32'h33, 32'h44};
      wr(4'hC, 32'h20, 8'd3, 2'b01, 4'hF, 1, 0);
      rx = '{32'h11, 32'h22, 32'h33, 32'h44};
      rd(4'hD, 32'h20, 8'd3, 2'b01);
      awid = 4'hE; awaddr = 32'h60; awlen = 8'd3; awburst = 2'b01; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      wdata = 32'h99; wstrb = 4'hF; wvalid = 1'b1;
      tick();
      wvalid = 1'b0;
      rst_n = 1'b0;
      #2;
      chk("mid_rst_wready", 32'(wready), 32'd0);
      chk("mid_rst_bvalid", 32'(bvalid), 32'd0);
      chk("mid_rst_awready", 32'(awready), 32'd0);
      #2;
      rst_n = 1'b1;
      tick();
      chk("post_rst_awready", 32'(awready), 32'd1);
      chk("post_rst_wready", 32'(wready), 32'd0);
      chk("post_rst_bvalid", 32'(bvalid), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
